// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared widths, FSM encoding and counter width for the pipeline controller
package pipe_ctrl_pkg;
    localparam int REG_IDX_WIDTH  = 5;
    localparam int PC_WIDTH       = 32;
    localparam int PCTL_CNT_WIDTH = 8;
    typedef enum logic {
        PCTL_ST_RUN     = 1'b0,
        PCTL_ST_MC_WAIT = 1'b1
    } pctl_state_e;
endpackage

// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard: combinational load-use hazard detect between ID sources and the load in EX
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic                     dec_rs1_en_i,
    input  logic [REG_IDX_WIDTH-1:0] dec_rs1_idx_i,
    input  logic                     dec_rs2_en_i,
    input  logic [REG_IDX_WIDTH-1:0] dec_rs2_idx_i,
    input  logic                     id_ex_rd_en_i,
    input  logic [REG_IDX_WIDTH-1:0] id_ex_rd_idx_i,
    input  logic                     id_ex_is_load_i,
    output logic                     hazard_o
);
    always_comb
        hazard_o = id_ex_is_load_i && id_ex_rd_en_i && (id_ex_rd_idx_i != '0) &&
                   ((dec_rs1_en_i && dec_rs1_idx_i == id_ex_rd_idx_i) ||
                    (dec_rs2_en_i && dec_rs2_idx_i == id_ex_rd_idx_i));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: front-end stall/flush controller (load-use, multi-cycle wait, redirect); PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dec_rs1_en_i,
    input  logic [REG_IDX_WIDTH-1:0] dec_rs1_idx_i,
    input  logic                     dec_rs2_en_i,
    input  logic [REG_IDX_WIDTH-1:0] dec_rs2_idx_i,
    input  logic                     id_ex_rd_en_i,
    input  logic [REG_IDX_WIDTH-1:0] id_ex_rd_idx_i,
    input  logic                     id_ex_is_load_i,
    input  logic                     ex_mc_req_i,
    input  logic                     ex_mc_done_i,
    input  logic                     ex_pipe_flush_i,
    input  logic [PC_WIDTH-1:0]      ex_pipe_flush_pc_i,
    output logic                     pc_stall_o,
    output logic                     if_id_stall_o,
    output logic                     id_ex_stall_o,
    output logic                     if_id_flush_o,
    output logic                     id_ex_flush_o,
    output logic                     pipe_flush_o,
    output logic [PC_WIDTH-1:0]      pipe_flush_pc_o,
    output logic                     mc_timeout_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]              perf_stall_cnt_o,
    output logic [31:0]              perf_flush_cnt_o
`endif
);
    localparam logic [PCTL_CNT_WIDTH-1:0] TO_LAST = PCTL_CNT_WIDTH'(MC_TIMEOUT - 1);
    pctl_state_e               r_state, w_state_nxt;
    logic [PCTL_CNT_WIDTH-1:0] r_wait_cnt;
    logic                      r_timeout;
    logic                      w_hazard, w_wait, w_to_hit, w_flush, w_stall_all, w_hz_stall;
    pipe_ctrl_hazard u_hazard (
        .dec_rs1_en_i    (dec_rs1_en_i),
        .dec_rs1_idx_i   (dec_rs1_idx_i),
        .dec_rs2_en_i    (dec_rs2_en_i),
        .dec_rs2_idx_i   (dec_rs2_idx_i),
        .id_ex_rd_en_i   (id_ex_rd_en_i),
        .id_ex_rd_idx_i  (id_ex_rd_idx_i),
        .id_ex_is_load_i (id_ex_is_load_i),
        .hazard_o        (w_hazard)
    );
    always_ff @(posedge clk)
        r_state <= !rst_n ? PCTL_ST_RUN : w_state_nxt;
    always_comb begin
        w_wait      = r_state == PCTL_ST_MC_WAIT;
        w_state_nxt = ex_pipe_flush_i ? PCTL_ST_RUN :
                      w_wait          ? (ex_mc_done_i ? PCTL_ST_RUN : PCTL_ST_MC_WAIT) :
                      ex_mc_req_i     ? PCTL_ST_MC_WAIT : PCTL_ST_RUN;
    end
    // wait_cnt is the 0-based index of the current MC_WAIT cycle
    always_ff @(posedge clk)
        if (!rst_n || w_state_nxt == PCTL_ST_RUN)
            r_wait_cnt <= '0;
        else if (w_wait && r_wait_cnt != '1)
            r_wait_cnt <= r_wait_cnt + 1'b1;
    always_ff @(posedge clk)
        if (!rst_n)
            r_timeout <= 1'b0;
        else if (w_to_hit)
            r_timeout <= 1'b1;
    always_comb begin
        w_to_hit        = w_wait && !ex_pipe_flush_i && !ex_mc_done_i && r_wait_cnt == TO_LAST;
        w_flush         = rst_n && ex_pipe_flush_i;
        w_stall_all     = rst_n && !ex_pipe_flush_i && (w_wait || ex_mc_req_i);
        w_hz_stall      = rst_n && !ex_pipe_flush_i && !w_wait && !ex_mc_req_i && w_hazard;
        pc_stall_o      = w_stall_all || w_hz_stall;
        if_id_stall_o   = w_stall_all || w_hz_stall;
        id_ex_stall_o   = w_stall_all;
        if_id_flush_o   = w_flush;
        id_ex_flush_o   = w_flush || w_hz_stall;
        pipe_flush_o    = w_flush;
        pipe_flush_pc_o = w_flush ? ex_pipe_flush_pc_i : '0;
        mc_timeout_o    = rst_n && (r_timeout || w_to_hit);
    end
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall, r_perf_flush;
    always_ff @(posedge clk)
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (pc_stall_o && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 1'b1;
            if (pipe_flush_o && r_perf_flush != '1)
                r_perf_flush <= r_perf_flush + 1'b1;
        end
    always_comb begin
        perf_stall_cnt_o = rst_n ? r_perf_stall : '0;
        perf_flush_cnt_o = rst_n ? r_perf_flush : '0;
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench, directed cases then random stimulus against a cycle-level behavioural model
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;
    localparam int MC_TO = 4;
    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     dec_rs1_en_i = 1'b0, dec_rs2_en_i = 1'b0;
    logic [REG_IDX_WIDTH-1:0] dec_rs1_idx_i = '0, dec_rs2_idx_i = '0, id_ex_rd_idx_i = '0;
    logic                     id_ex_rd_en_i = 1'b0, id_ex_is_load_i = 1'b0;
    logic                     ex_mc_req_i = 1'b0, ex_mc_done_i = 1'b0, ex_pipe_flush_i = 1'b0;
    logic [PC_WIDTH-1:0]      ex_pipe_flush_pc_i = '0;
    logic                     pc_stall_o, if_id_stall_o, id_ex_stall_o;
    logic                     if_id_flush_o, id_ex_flush_o, pipe_flush_o, mc_timeout_o;
    logic [PC_WIDTH-1:0]      pipe_flush_pc_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]              perf_stall_cnt_o, perf_flush_cnt_o;
`endif
    typedef struct packed {
        logic                pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, pipe_flush, timeout;
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         perf_stall, perf_flush;
    } obs_t;
    obs_t exp_q[$];
    int   cyc_q[$];
    int   n_tests = 0, n_fail = 0, cyc = 0;
    bit   m_waiting = 0, m_to = 0;
    int   m_k = 0;
    int unsigned m_ps = 0, m_pf = 0;
    obs_t mon_e, mon_a;
    int   mon_c;

    always #5 clk = ~clk;

    pipe_ctrl #(.MC_TIMEOUT(MC_TO)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .dec_rs1_en_i       (dec_rs1_en_i),
        .dec_rs1_idx_i      (dec_rs1_idx_i),
        .dec_rs2_en_i       (dec_rs2_en_i),
        .dec_rs2_idx_i      (dec_rs2_idx_i),
        .id_ex_rd_en_i      (id_ex_rd_en_i),
        .id_ex_rd_idx_i     (id_ex_rd_idx_i),
        .id_ex_is_load_i    (id_ex_is_load_i),
        .ex_mc_req_i        (ex_mc_req_i),
        .ex_mc_done_i       (ex_mc_done_i),
        .ex_pipe_flush_i    (ex_pipe_flush_i),
        .ex_pipe_flush_pc_i (ex_pipe_flush_pc_i),
        .pc_stall_o         (pc_stall_o),
        .if_id_stall_o      (if_id_stall_o),
        .id_ex_stall_o      (id_ex_stall_o),
        .if_id_flush_o      (if_id_flush_o),
        .id_ex_flush_o      (id_ex_flush_o),
        .pipe_flush_o       (pipe_flush_o),
        .pipe_flush_pc_o    (pipe_flush_pc_o),
        .mc_timeout_o       (mc_timeout_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt_o   (perf_stall_cnt_o),
        .perf_flush_cnt_o   (perf_flush_cnt_o)
`endif
    );

    // Model: m_k counts MC_WAIT cycles 1-based; timeout fires on the MC_TO-th one without done
    task automatic cycle();
        obs_t e;
        bit   hz;
        e  = '0;
        hz = id_ex_is_load_i && id_ex_rd_en_i && id_ex_rd_idx_i != 0 &&
             ((dec_rs1_en_i && dec_rs1_idx_i == id_ex_rd_idx_i) ||
              (dec_rs2_en_i && dec_rs2_idx_i == id_ex_rd_idx_i));
        if (!rst_n) begin
            m_waiting = 0; m_k = 0; m_to = 0; m_ps = 0; m_pf = 0;
        end else begin
`ifdef PIPE_CTRL_PERF_EN
            e.perf_stall = m_ps;
            e.perf_flush = m_pf;
`endif
            if (ex_pipe_flush_i) begin
                e.pipe_flush = 1; e.pc = ex_pipe_flush_pc_i; e.if_id_flush = 1; e.id_ex_flush = 1;
                m_waiting = 0;
            end else if (m_waiting) begin
                e.pc_stall = 1; e.if_id_stall = 1; e.id_ex_stall = 1;
                if (!ex_mc_done_i && m_k == MC_TO) m_to = 1;
                if (ex_mc_done_i) m_waiting = 0;
                else m_k++;
            end else if (ex_mc_req_i) begin
                e.pc_stall = 1; e.if_id_stall = 1; e.id_ex_stall = 1;
                m_waiting = 1; m_k = 1;
            end else if (hz) begin
                e.pc_stall = 1; e.if_id_stall = 1; e.id_ex_flush = 1;
            end
            e.timeout = m_to;
            if (e.pc_stall) m_ps++;
            if (e.pipe_flush) m_pf++;
        end
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1; dec_rs1_en_i = 0; dec_rs2_en_i = 0; dec_rs1_idx_i = 0; dec_rs2_idx_i = 0;
        id_ex_rd_en_i = 0; id_ex_rd_idx_i = 0; id_ex_is_load_i = 0;
        ex_mc_req_i = 0; ex_mc_done_i = 0; ex_pipe_flush_i = 0; ex_pipe_flush_pc_i = 0;
    endtask

    task automatic load_use(input logic [REG_IDX_WIDTH-1:0] rd, input logic rs2_en);
        id_ex_is_load_i = 1; id_ex_rd_en_i = 1; id_ex_rd_idx_i = rd;
        dec_rs1_en_i = 1; dec_rs1_idx_i = rd; dec_rs2_en_i = rs2_en; dec_rs2_idx_i = 1;
    endtask

    always @(negedge clk)
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_c = cyc_q.pop_front();
            mon_a = '0;
            mon_a.pc_stall    = pc_stall_o;
            mon_a.if_id_stall = if_id_stall_o;
            mon_a.id_ex_stall = id_ex_stall_o;
            mon_a.if_id_flush = if_id_flush_o;
            mon_a.id_ex_flush = id_ex_flush_o;
            mon_a.pipe_flush  = pipe_flush_o;
            mon_a.timeout     = mc_timeout_o;
            mon_a.pc          = pipe_flush_pc_o;
`ifdef PIPE_CTRL_PERF_EN
            mon_a.perf_stall  = perf_stall_cnt_o;
            mon_a.perf_flush  = perf_flush_cnt_o;
`endif
            n_tests++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL cycle %0d outputs: got %h expected %h", mon_c, mon_a, mon_e);
            end
        end

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk); #1;
        cycle(); cycle();
        idle(); cycle();
        load_use(5, 1); cycle();
        id_ex_is_load_i = 0; id_ex_rd_en_i = 0; cycle();
        load_use(0, 1); cycle();
        load_use(5, 0); dec_rs1_idx_i = 1; dec_rs2_idx_i = 5; cycle();
        idle(); ex_mc_req_i = 1; cycle();
        ex_mc_req_i = 0; cycle(); cycle();
        ex_mc_done_i = 1; cycle();
        idle(); cycle();
        ex_mc_req_i = 1; cycle();
        idle(); cycle();
        load_use(7, 1); ex_pipe_flush_i = 1; ex_pipe_flush_pc_i = 32'h80; cycle();
        idle(); cycle();
        ex_mc_req_i = 1; cycle();
        idle(); repeat (5) cycle();
        ex_mc_done_i = 1; cycle();
        idle(); cycle(); cycle();
        ex_mc_req_i = 1; cycle();
        idle(); cycle();
        rst_n = 0; cycle();
        idle(); cycle();
        for (int i = 0; i < 3000; i++) begin
            rst_n              = $urandom_range(0, 149) != 0;
            dec_rs1_en_i       = $urandom_range(0, 1);
            dec_rs2_en_i       = $urandom_range(0, 1);
            dec_rs1_idx_i      = REG_IDX_WIDTH'($urandom_range(0, 3));
            dec_rs2_idx_i      = REG_IDX_WIDTH'($urandom_range(0, 3));
            id_ex_rd_en_i      = $urandom_range(0, 3) != 0;
            id_ex_rd_idx_i     = REG_IDX_WIDTH'($urandom_range(0, 3));
            id_ex_is_load_i    = $urandom_range(0, 1);
            ex_mc_req_i        = $urandom_range(0, 9) == 0;
            ex_mc_done_i       = $urandom_range(0, 6) == 0;
            ex_pipe_flush_i    = $urandom_range(0, 11) == 0;
            ex_pipe_flush_pc_i = $urandom;
            cycle();
        end
        idle();
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
